// File: rtl/tilegroup_dispatch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : tilegroup_dispatch_queue_if
// Brief    : Descriptor input strobe and valid/ready dispatch handshake
//            bundle for the TileGroup dispatch queue.
// Revision : 1.0 - initial release
// ============================================================================
interface tilegroup_dispatch_queue_if #(
  parameter int WIDTH     = 16,
  parameter int GID_WIDTH = 16
);
  // Producer side: single-cycle strobe, no backpressure.
  logic                 in_valid;
  logic [GID_WIDTH-1:0] in_gid;
  logic [WIDTH-1:0]     in_row_group_idx;
  logic [WIDTH-1:0]     in_col_tile_idx;
  logic [WIDTH-1:0]     in_col_start;
  logic [WIDTH-1:0]     in_col_end;

  // Scheduler side: valid/ready dispatch of the head descriptor.
  logic                 out_valid;
  logic                 out_ready;
  logic [GID_WIDTH-1:0] out_gid;
  logic [WIDTH-1:0]     out_row_group_idx;
  logic [WIDTH-1:0]     out_col_tile_idx;
  logic [WIDTH-1:0]     out_col_start;
  logic [WIDTH-1:0]     out_col_end;

  // Environment view: drives descriptors and the ready, observes the head.
  modport master (
    output in_valid, in_gid, in_row_group_idx, in_col_tile_idx,
           in_col_start, in_col_end, out_ready,
    input  out_valid, out_gid, out_row_group_idx, out_col_tile_idx,
           out_col_start, out_col_end
  );

  // Queue view.
  modport slave (
    input  in_valid, in_gid, in_row_group_idx, in_col_tile_idx,
           in_col_start, in_col_end, out_ready,
    output out_valid, out_gid, out_row_group_idx, out_col_tile_idx,
           out_col_start, out_col_end
  );
endinterface
`default_nettype wire

// File: rtl/tilegroup_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tilegroup_dispatch_queue
// Brief    : Buffers TileGroup descriptors from a non-backpressured producer
//            in a (DEPTH-1)-entry memory FIFO followed by one output register,
//            and dispatches them over valid/ready. Reports occupancy,
//            high-water mark, drop statistics and dispatch count.
//            Optional macro GID_SEQ_CHECK_EN enables the group-ID sequence
//            checker driving seq_err; without it seq_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module tilegroup_dispatch_queue #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 16,
  parameter int GID_WIDTH = 16,
  parameter int CNT_WIDTH = 16,
  localparam int OCC_W    = $clog2(DEPTH + 1)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  flush,
  tilegroup_dispatch_queue_if.slave  bus,
  output logic [OCC_W-1:0]           occupancy,
  output logic [OCC_W-1:0]           high_water,
  output logic                       overflow,
  output logic [CNT_WIDTH-1:0]       drop_count,
  output logic [31:0]                dispatched_count,
  output logic                       seq_err
);

  localparam int              c_DESC_W   = GID_WIDTH + 4 * WIDTH;
  localparam int              c_MEM_DEPTH = DEPTH - 1;
  localparam int              c_PTR_W    = (c_MEM_DEPTH > 1) ? $clog2(c_MEM_DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(c_MEM_DEPTH - 1);
  localparam logic [OCC_W-1:0]   c_FULL     = OCC_W'(DEPTH);

  // Storage and state
  logic [c_DESC_W-1:0]  r_mem [c_MEM_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]     r_mem_cnt;
  logic                 r_out_valid;
  logic [c_DESC_W-1:0]  r_out_desc;
  logic [OCC_W-1:0]     r_occupancy;
  logic [OCC_W-1:0]     r_high_water;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_drop_count;
  logic [31:0]          r_dispatched;

  // Datapath / control
  logic [c_DESC_W-1:0]  w_in_desc;
  logic [c_DESC_W-1:0]  w_mem_rd_data;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_out_load;
  logic                 w_mem_rd;
  logic                 w_bypass;
  logic                 w_mem_wr;
  logic [OCC_W-1:0]     w_occ_next;

  assign w_in_desc = {bus.in_gid, bus.in_row_group_idx, bus.in_col_tile_idx,
                      bus.in_col_start, bus.in_col_end};
  assign w_mem_rd_data = r_mem[r_rd_ptr];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_pop      = r_out_valid & bus.out_ready;
  assign w_full     = (r_occupancy == c_FULL);
  assign w_push     = bus.in_valid & ~flush & (~w_full | w_pop);
  assign w_drop     = bus.in_valid & ~flush & w_full & ~w_pop;

  // The output register refills whenever it is empty or being popped. Memory
  // entries always go first; a push only bypasses the memory when it is empty,
  // which gives the one-cycle latency into an idle queue.
  assign w_out_load = ~r_out_valid | w_pop;
  assign w_mem_rd   = w_out_load & (r_mem_cnt != '0);
  assign w_bypass   = w_out_load & (r_mem_cnt == '0) & w_push;
  assign w_mem_wr   = w_push & ~w_bypass;

  assign w_occ_next = flush ? '0
                    : r_occupancy + OCC_W'(w_push) - OCC_W'(w_pop);

  // Memory array write port; contents are never observed before being written.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= w_in_desc;
    end
  end

  // Memory pointers and entry count, wrapping at DEPTH-1 entries by compare.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
    end else begin
      if (w_mem_wr) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_mem_rd) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
      end
      r_mem_cnt <= r_mem_cnt + OCC_W'(w_mem_wr) - OCC_W'(w_mem_rd);
    end
  end

  // Output register stage; holds its contents while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_out_valid <= 1'b0;
      r_out_desc  <= '0;
    end else if (w_mem_rd) begin
      r_out_valid <= 1'b1;
      r_out_desc  <= w_mem_rd_data;
    end else if (w_bypass) begin
      r_out_valid <= 1'b1;
      r_out_desc  <= w_in_desc;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  // Occupancy and statistics; flush clears occupancy but keeps the statistics,
  // and a pop coinciding with flush is still counted as dispatched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occupancy  <= '0;
      r_high_water <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_dispatched <= '0;
    end else begin
      r_occupancy <= w_occ_next;
      if (w_occ_next > r_high_water) begin
        r_high_water <= w_occ_next;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + CNT_WIDTH'(1);
        end
      end
      if (w_pop) begin
        r_dispatched <= r_dispatched + 32'd1;
      end
    end
  end

`ifdef GID_SEQ_CHECK_EN
  logic [GID_WIDTH-1:0] r_prev_gid;
  logic                 r_have_prev;
  logic                 r_seq_err;

  // Group-ID continuity check on accepted pushes; first push after reset or
  // flush only seeds the reference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_gid  <= '0;
      r_have_prev <= 1'b0;
      r_seq_err   <= 1'b0;
    end else if (flush) begin
      r_have_prev <= 1'b0;
    end else if (w_push) begin
      r_prev_gid  <= bus.in_gid;
      r_have_prev <= 1'b1;
      if (r_have_prev && (bus.in_gid != r_prev_gid + GID_WIDTH'(1))) begin
        r_seq_err <= 1'b1;
      end
    end
  end

  assign seq_err = r_seq_err;
`else
  assign seq_err = 1'b0;
`endif

  assign bus.out_valid         = r_out_valid;
  assign bus.out_col_end       = r_out_desc[WIDTH-1:0];
  assign bus.out_col_start     = r_out_desc[2*WIDTH-1:WIDTH];
  assign bus.out_col_tile_idx  = r_out_desc[3*WIDTH-1:2*WIDTH];
  assign bus.out_row_group_idx = r_out_desc[4*WIDTH-1:3*WIDTH];
  assign bus.out_gid           = r_out_desc[c_DESC_W-1:4*WIDTH];

  assign occupancy        = r_occupancy;
  assign high_water       = r_high_water;
  assign overflow         = r_overflow;
  assign drop_count       = r_drop_count;
  assign dispatched_count = r_dispatched;

endmodule
`default_nettype wire

// File: tb/tb_tilegroup_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_tilegroup_dispatch_queue
// Brief    : Self-checking bench for tilegroup_dispatch_queue with a
//            queue-based reference model (DEPTH=8, 16-bit fields).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tilegroup_dispatch_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [3:0]  occupancy;
  logic [3:0]  high_water;
  logic        overflow;
  logic [15:0] drop_count;
  logic [31:0] dispatched_count;
  logic        seq_err;

  tilegroup_dispatch_queue_if #(.WIDTH(16), .GID_WIDTH(16)) bus ();

  tilegroup_dispatch_queue #(
    .DEPTH(DEPTH), .WIDTH(16), .GID_WIDTH(16), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .occupancy(occupancy), .high_water(high_water), .overflow(overflow),
    .drop_count(drop_count), .dispatched_count(dispatched_count),
    .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the queue holds everything the DUT holds,
  // head first, including the descriptor on the output.
  logic [79:0] m_q[$];
  int          m_hw;
  bit          m_over;
  logic [15:0] m_drop;
  logic [31:0] m_disp;
  bit          m_seq;
  logic [15:0] m_prev;
  bit          m_have_prev;

  function automatic logic [79:0] out_desc();
    return {bus.out_gid, bus.out_row_group_idx, bus.out_col_tile_idx,
            bus.out_col_start, bus.out_col_end};
  endfunction

  task automatic drive(input bit v, input logic [15:0] g, input logic [15:0] r,
                       input logic [15:0] c, input logic [15:0] s, input logic [15:0] e);
    bus.in_valid = v; bus.in_gid = g; bus.in_row_group_idx = r;
    bus.in_col_tile_idx = c; bus.in_col_start = s; bus.in_col_end = e;
  endtask

  task automatic drive_rand(input bit v, input logic [15:0] g);
    drive(v, g, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step();
    logic [79:0] d;
    bit pop, full;
    d = {bus.in_gid, bus.in_row_group_idx, bus.in_col_tile_idx,
         bus.in_col_start, bus.in_col_end};
    if (!rst_n) begin
      m_q.delete(); m_hw = 0; m_over = 0; m_drop = 0; m_disp = 0;
      m_seq = 0; m_prev = 0; m_have_prev = 0;
    end else if (flush) begin
      if (m_q.size() > 0 && bus.out_ready) m_disp++;
      m_q.delete();
      m_have_prev = 0;
    end else begin
      pop  = (m_q.size() > 0) && bus.out_ready;
      full = (m_q.size() == DEPTH);
      if (pop) begin
        void'(m_q.pop_front());
        m_disp++;
      end
      if (bus.in_valid) begin
        if (!full || pop) begin
`ifdef GID_SEQ_CHECK_EN
          if (m_have_prev && bus.in_gid != 16'(m_prev + 16'd1)) m_seq = 1;
`endif
          m_prev = bus.in_gid;
          m_have_prev = 1;
          m_q.push_back(d);
        end else begin
          m_over = 1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
      end
      if (m_q.size() > m_hw) m_hw = m_q.size();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    vectors++;
    if ({bus.out_valid, out_desc()} !== 81'd0) begin
      miscompares++;
      $display("FAIL reset_out: got valid=%b desc=%h, want 0", bus.out_valid, out_desc());
    end
    vectors++;
    if ({occupancy, high_water, overflow, drop_count, dispatched_count, seq_err} !== 58'd0) begin
      miscompares++;
      $display("FAIL reset_stats: got occ=%0d hw=%0d ovf=%b drop=%0d disp=%0d seq=%b, want all 0",
               occupancy, high_water, overflow, drop_count, dispatched_count, seq_err);
    end
  endtask

  task automatic test_single();
    logic [79:0] exp_d;
    do_reset();
    bus.out_ready = 1'b1;
    drive(1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd479);
    exp_d = {16'd1, 16'd0, 16'd0, 16'd0, 16'd479};
    step();
    drive(0, 0, 0, 0, 0, 0);
    vectors++;
    if (bus.out_valid !== 1'b1 || out_desc() !== exp_d) begin
      miscompares++;
      $display("FAIL single_latency: got valid=%b desc=%h, want valid=1 desc=%h",
               bus.out_valid, out_desc(), exp_d);
    end
    step();
    vectors++;
    if (dispatched_count !== 32'd1 || occupancy !== 4'd0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: got disp=%0d occ=%0d valid=%b, want 1 0 0",
               dispatched_count, occupancy, bus.out_valid);
    end
  endtask

  task automatic test_fill_drop();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive_rand(1, 16'(i));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    vectors++;
    if (occupancy !== 4'd8 || high_water !== 4'd8 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fill: got occ=%0d hw=%0d ovf=%b, want 8 8 0", occupancy, high_water, overflow);
    end
    for (int i = 0; i < 2; i++) begin
      drive_rand(1, 16'(100 + i));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    vectors++;
    if (drop_count !== 16'd2 || overflow !== 1'b1 || occupancy !== 4'd8) begin
      miscompares++;
      $display("FAIL drop: got drop=%0d ovf=%b occ=%0d, want 2 1 8", drop_count, overflow, occupancy);
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_gid !== 16'(i) || out_desc() !== m_q[0]) begin
        miscompares++;
        $display("FAIL drain_order: got valid=%b gid=%0d desc=%h, want gid=%0d desc=%h",
                 bus.out_valid, bus.out_gid, out_desc(), i, m_q[0]);
      end
      step();
    end
    vectors++;
    if (occupancy !== 4'd0 || dispatched_count !== 32'd8 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_end: got occ=%0d disp=%0d valid=%b, want 0 8 0",
               occupancy, dispatched_count, bus.out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 20; i < 28; i++) begin
      drive_rand(1, 16'(i));
      step();
    end
    bus.out_ready = 1'b1;
    drive_rand(1, 16'd28);
    step();
    drive(0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    vectors++;
    if (occupancy !== 4'd8 || drop_count !== 16'd0 || bus.out_gid !== 16'd21 ||
        dispatched_count !== 32'd1) begin
      miscompares++;
      $display("FAIL full_push_pop: got occ=%0d drop=%0d gid=%0d disp=%0d, want 8 0 21 1",
               occupancy, drop_count, bus.out_gid, dispatched_count);
    end
    bus.out_ready = 1'b1;
    for (int i = 21; i <= 28; i++) begin
      vectors++;
      if (bus.out_gid !== 16'(i) || out_desc() !== m_q[0]) begin
        miscompares++;
        $display("FAIL full_push_pop_order: got gid=%0d, want %0d", bus.out_gid, i);
      end
      step();
    end
  endtask

  task automatic test_stall();
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] exp_gid[4] = '{16'd41, 16'd41, 16'd41, 16'd42};
    do_reset();
    for (int i = 40; i < 43; i++) begin
      drive_rand(1, 16'(i));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.out_ready = pat[i];
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_gid !== exp_gid[i] || out_desc() !== m_q[0]) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got valid=%b gid=%0d desc=%h, want gid=%0d desc=%h",
                 i, bus.out_valid, bus.out_gid, out_desc(), exp_gid[i], m_q[0]);
      end
    end
    bus.out_ready = 1'b1;
    step();
    vectors++;
    if (dispatched_count !== 32'd3 || occupancy !== 4'd0) begin
      miscompares++;
      $display("FAIL stall_count: got disp=%0d occ=%0d, want 3 0", dispatched_count, occupancy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_rand(1, 16'(60 + i));
      step();
    end
    flush = 1'b1;
    drive_rand(1, 16'd99);
    step();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    vectors++;
    if (occupancy !== 4'd0 || bus.out_valid !== 1'b0 || drop_count !== 16'd0 ||
        high_water !== 4'd5) begin
      miscompares++;
      $display("FAIL flush: got occ=%0d valid=%b drop=%0d hw=%0d, want 0 0 0 5",
               occupancy, bus.out_valid, drop_count, high_water);
    end
  endtask

  task automatic test_seq();
    logic [15:0] gids[3] = '{16'd1, 16'd2, 16'd4};
    bit exp_seq;
`ifdef GID_SEQ_CHECK_EN
    exp_seq = 1'b1;
`else
    exp_seq = 1'b0;
`endif
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1, gids[i]);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    vectors++;
    if (seq_err !== exp_seq) begin
      miscompares++;
      $display("FAIL seq_err: got %b, want %b", seq_err, exp_seq);
    end
    step();
    step();
    vectors++;
    if (dispatched_count !== 32'd3 || occupancy !== 4'd0) begin
      miscompares++;
      $display("FAIL seq_dispatch: got disp=%0d occ=%0d, want 3 0", dispatched_count, occupancy);
    end
  endtask

  task automatic test_random();
    logic [58:0] exp_s, act_s;
    int rdy_pct, in_pct;
    logic [15:0] next_gid;
    do_reset();
    next_gid = 16'd1;
    for (int phase = 0; phase < 4; phase++) begin
      rdy_pct = (phase % 2 == 0) ? 30 : 85;
      in_pct  = (phase < 2) ? 80 : 50;
      for (int cyc = 0; cyc < 150; cyc++) begin
        bus.out_ready = ($urandom_range(99) < rdy_pct);
        flush = ($urandom_range(63) == 0);
        if ($urandom_range(15) == 0) drive_rand($urandom_range(99) < in_pct, 16'($urandom));
        else drive_rand($urandom_range(99) < in_pct, next_gid);
        if (bus.in_valid) next_gid = bus.in_gid + 16'd1;
        step();
        exp_s = {m_q.size() > 0, 4'(m_q.size()), 4'(m_hw), m_over, m_drop, m_disp, m_seq};
        act_s = {bus.out_valid, occupancy, high_water, overflow, drop_count,
                 dispatched_count, seq_err};
        vectors++;
        if (act_s !== exp_s) begin
          miscompares++;
          $display("FAIL random_status p%0d c%0d: got %h, want %h", phase, cyc, act_s, exp_s);
        end
        if (m_q.size() > 0) begin
          vectors++;
          if (out_desc() !== m_q[0]) begin
            miscompares++;
            $display("FAIL random_head p%0d c%0d: got %h, want %h", phase, cyc, out_desc(), m_q[0]);
          end
        end
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_rand(1, 16'(200 + i));
      step();
    end
    rst_n = 1'b0;
    drive_rand(1, 16'd300);
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    vectors++;
    if ({bus.out_valid, out_desc(), occupancy, high_water, overflow, drop_count,
         dispatched_count, seq_err} !== 139'd0) begin
      miscompares++;
      $display("FAIL reset_midstream: got valid=%b desc=%h occ=%0d hw=%0d ovf=%b drop=%0d disp=%0d seq=%b, want all 0",
               bus.out_valid, out_desc(), occupancy, high_water, overflow, drop_count,
               dispatched_count, seq_err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_single();
    test_fill_drop();
    test_full_push_pop();
    test_stall();
    test_flush();
    test_seq();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
